// File: rtl/vga_pixel_output_pkg.sv
// Shared VGA definitions: pixel-output FSM states, RGB565 layout and the nominal
// frame geometry also used by the timing generator.
package vga_pixel_output_pkg;

   localparam int RED_W = 5;
   localparam int GRN_W = 6;
   localparam int BLU_W = 5;
   localparam int PIX_W = RED_W + GRN_W + BLU_W;
   localparam int X_RES = 640;
   localparam int Y_RES = 480;

   typedef enum logic [1:0] {
      SEEK  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } vga_state_e;

   // {R,G,B} with red in the MSBs
   function automatic logic [RED_W-1:0] pix_red(input logic [PIX_W-1:0] p);
      return p[PIX_W-1 -: RED_W];
   endfunction

   function automatic logic [GRN_W-1:0] pix_grn(input logic [PIX_W-1:0] p);
      return p[GRN_W+BLU_W-1 -: GRN_W];
   endfunction

   function automatic logic [BLU_W-1:0] pix_blu(input logic [PIX_W-1:0] p);
      return p[BLU_W-1:0];
   endfunction

endpackage

// File: rtl/vga_pixel_output_if.sv
// Frame-FIFO head interface: the FIFO (master) presents a word, the pixel stage
// (slave) pops it with pix_ready.
interface vga_pixel_output_if #(
   parameter int PIX_W = 16
);
   logic [PIX_W-1:0] pix_data;
   logic             pix_sof;
   logic             pix_valid;
   logic             pix_ready;

   modport master (output pix_data, pix_sof, pix_valid, input pix_ready);
   modport slave  (input pix_data, pix_sof, pix_valid, output pix_ready);
endinterface

// File: rtl/vga_pixel_output_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones, cleared by reset.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}}))
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/vga_pixel_output.sv
// Last VGA stage: pops frame-FIFO pixels during the active area, registers RGB and
// sync together, locks to the FIFO start-of-frame marker and recovers on errors.
module vga_pixel_output
   import vga_pixel_output_pkg::*;
#(
   parameter int R_BITS = RED_W,
   parameter int G_BITS = GRN_W,
   parameter int B_BITS = BLU_W,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_display,
   input  logic              h_sync_in,
   input  logic              v_sync_in,
   vga_pixel_output_if.slave fifo,
   output logic [R_BITS-1:0] vga_r,
   output logic [G_BITS-1:0] vga_g,
   output logic [B_BITS-1:0] vga_b,
   output logic              vga_h_sync,
   output logic              vga_v_sync,
   output logic              frame_locked,
   output logic [CNT_W-1:0]  underflow_cnt,
   output logic [CNT_W-1:0]  resync_cnt
);
   localparam int PW = R_BITS + G_BITS + B_BITS;

   vga_state_e  state_q, state_d;
   logic [PW-1:0] rgb_q, rgb_d;
   logic        seen_active_q, seen_active_d;
   logic        hs_q, vs_q;
   logic        frame_start;
   logic        ready_c;
   logic        uf_inc, rs_inc;

   always_comb begin
      frame_start   = in_display & ~seen_active_q;
      seen_active_d = seen_active_q;
      if (v_sync_in)       seen_active_d = 1'b0;
      else if (in_display) seen_active_d = 1'b1;

      state_d = state_q;
      rgb_d   = '0;
      ready_c = 1'b0;
      uf_inc  = 1'b0;
      rs_inc  = 1'b0;
      case (state_q)
         SEEK: begin
            // Anything ahead of an SOF word is stale and gets flushed.
            ready_c = ~(fifo.pix_valid & fifo.pix_sof);
            if (fifo.pix_valid & fifo.pix_sof) state_d = ARMED;
         end
         ARMED: begin
            ready_c = frame_start;
            if (frame_start & fifo.pix_valid) begin
               rgb_d   = fifo.pix_data;
               state_d = RUN;
            end
         end
         RUN: begin
            ready_c = in_display & fifo.pix_valid & (fifo.pix_sof == frame_start);
            if (in_display & ~fifo.pix_valid) begin
               uf_inc  = 1'b1;
               state_d = SEEK;
            end else if (frame_start & ~fifo.pix_sof) begin
               rs_inc  = 1'b1;
               state_d = SEEK;
            end else if (in_display & ~frame_start & fifo.pix_sof) begin
               // Short frame: keep the next SOF word at the head for the next frame.
               rs_inc  = 1'b1;
               state_d = ARMED;
            end else if (in_display) begin
               rgb_d = fifo.pix_data;
            end
         end
         default: state_d = SEEK;
      endcase
   end

   assign fifo.pix_ready = rst_n & ready_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= SEEK;
         rgb_q         <= '0;
         seen_active_q <= 1'b0;
         hs_q          <= 1'b0;
         vs_q          <= 1'b0;
      end else begin
         state_q       <= state_d;
         rgb_q         <= rgb_d;
         seen_active_q <= seen_active_d;
         hs_q          <= h_sync_in;
         vs_q          <= v_sync_in;
      end
   end

   assign vga_r        = rgb_q[PW-1 -: R_BITS];
   assign vga_g        = rgb_q[G_BITS+B_BITS-1 -: G_BITS];
   assign vga_b        = rgb_q[B_BITS-1:0];
   assign vga_h_sync   = hs_q;
   assign vga_v_sync   = vs_q;
   assign frame_locked = (state_q == RUN);

   sat_counter #(.CNT_W(CNT_W)) u_underflow_cnt (
      .clk(clk), .rst_n(rst_n), .inc(uf_inc), .count(underflow_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_resync_cnt (
      .clk(clk), .rst_n(rst_n), .inc(rs_inc), .count(resync_cnt)
   );
endmodule
